keypad_decoder: RTL and testbench
=================================

# keypad_decoder

Reads the 4x4 calculator keypad's row lines back while the column ring counter drives one-hot column strobes. It debounces one key across repeated scans and emits a 4-bit key code with a one-cycle valid pulse. It sits between the keypad matrix and the calculator input FSM.

## Interface
- DEBOUNCE_SCANS, 4, number of consecutive matching (or non-matching) scans required to accept a press (or a release); legal range ≥1
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- enable  in  1  scan enable, shared with the column ring counter
- col  in  4  column currently driven; one-hot, bit k = column k
- row  in  4  row readback, active-high; bit r = row r
- key_code  out  4  {row_idx[1:0], col_idx[1:0]} of the accepted key; holds until the next accepted press
- key_valid  out  1  one-cycle pulse when a press is accepted
- key_held  out  1  high from acceptance until release is accepted
- key_error  out  1  multi-row flag; see Configuration

## Operation
- Reset values: key_code=0, key_valid=0, key_held=0, key_error=0, state IDLE, counter 0.
- Sample rule: a sample is taken on every clk edge with enable=1. It is valid only if col is one-hot. Non-one-hot col (including 0000) is ignored and changes no state.
- Hit: at least one row bit is high in a valid sample. Row index is the lowest set row bit.
- States:
  - IDLE: on the first hit, latch (row_idx, col_idx), set cnt=1, go to CANDIDATE. If DEBOUNCE_SCANS=1, go directly to PRESSED.
  - CANDIDATE: only samples whose col equals the latched column are evaluated. If the same row is present, cnt++. When cnt reaches DEBOUNCE_SCANS, go to PRESSED. If the row is absent, or a different row is the lowest hit, go to IDLE with cnt=0.
  - PRESSED (entry): pulse key_valid, load key_code, set key_held=1, cnt=0. At the latched column, a row absence increments cnt and a row presence clears it. When cnt reaches DEBOUNCE_SCANS, go to IDLE and set key_held=0.
- Other keys pressed while in CANDIDATE or PRESSED are ignored. There is no rollover or queueing.
- enable=0 freezes state, cnt, key_code and key_held. key_valid is forced to 0.
- Counter width is $clog2(DEBOUNCE_SCANS+1). The counter saturates and never wraps.

## Timing
- Ring counter advances one column per clk, so a full scan is 4 cycles.
- Press latency: key_valid goes high on the edge after the DEBOUNCE_SCANS-th matching sample, which is (DEBOUNCE_SCANS-1)*4+1 cycles after the first hit. For the default this is 13 cycles.
- key_code and key_held update on the same edge as the key_valid pulse.
- Release latency: key_held falls DEBOUNCE_SCANS*4 cycles after the first absent sample, give or take one scan alignment.
- A reset low mid-operation puts every output at its reset value on the next edge, with no key_valid pulse.
- Reset and enable are sampled together on the same edge; reset has priority.

## Configuration
- KEYPAD_MULTIKEY_ERR_EN defined:
  - A valid sample with two or more row bits set drives key_error=1 for one cycle.
  - That sample is treated as a miss in CANDIDATE and as an absence in PRESSED.
  - In IDLE it starts no candidate.
- Undefined: key_error is tied 0, and the lowest set row wins as described above.

## Structure
- keypad_pkg holds:
  - the state enum (IDLE, CANDIDATE, PRESSED)
  - KEY_W=4 and ROWS=COLS=4
  - a function that packs row/col indices into a key code
- Sub-module onehot_enc (4-bit one-hot to 2-bit index plus an is_onehot flag) is instantiated once for col.
- Row priority encoding stays inline.

## Test plan
- Reset low for 2 cycles with row=0010 held → all outputs 0. After release with no key, key_valid stays 0 for 40 cycles.
- Press row 2 at column 1 (row=0100 while col=0010), DEBOUNCE_SCANS=4 → key_valid is a single pulse 13 cycles after the first hit, key_code=4'b1001, key_held=1.
- Bounce: key present for 2 scans, absent for 1, then stable → no pulse until 4 consecutive matching scans; exactly one key_valid.
- Release: after acceptance, drop row → key_held falls after 4 absent scans. Re-press → second key_valid with the same key_code.
- Second key (row 0, col 3) pressed while the first is PRESSED → ignored, key_code unchanged. With KEYPAD_MULTIKEY_ERR_EN, two rows in one column → key_error pulse and no acceptance.
- enable=0 mid-CANDIDATE for 10 cycles → no state change. Reset low mid-PRESSED → key_held=0 on the next edge, key_code=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad decoder.
// Build option: KEYPAD_MULTIKEY_ERR_EN (see keypad_decoder.sv).
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        PRESSED   = 2'd2
    } kp_state_t;

    // Key code layout is {row_idx, col_idx}
    function automatic logic [KEY_W-1:0] pack_key(
        input logic [IDX_W-1:0] row_idx,
        input logic [IDX_W-1:0] col_idx
    );
        return {row_idx, col_idx};
    endfunction

endpackage

// File: rtl/onehot_enc.sv
// 4-bit one-hot to 2-bit index encoder with a one-hot validity flag.
module onehot_enc
    import keypad_pkg::*;
(
    input  logic [3:0] vec,
    output logic [1:0] idx,
    output logic       is_onehot
);

    logic [COLS-1:0]  vec_s;
    logic [IDX_W-1:0] idx_s;
    logic             onehot_s;

    assign vec_s = vec;

    // Decode the strobe; anything other than exactly one set bit is flagged
    always_comb begin
        idx_s    = 2'd0;
        onehot_s = 1'b1;
        case (vec_s)
            4'b0001: idx_s = 2'd0;
            4'b0010: idx_s = 2'd1;
            4'b0100: idx_s = 2'd2;
            4'b1000: idx_s = 2'd3;
            default: begin
                idx_s    = 2'd0;
                onehot_s = 1'b0;
            end
        endcase
    end

    assign idx       = idx_s;
    assign is_onehot = onehot_s;

endmodule

// File: rtl/keypad_decoder.sv
// Debouncing 4x4 keypad decoder: accepts one key per press, reports code/valid/held.
// Build option: KEYPAD_MULTIKEY_ERR_EN turns multi-row samples into key_error pulses.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_error
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZRO = CNT_W'(0);

    kp_state_t        state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [IDX_W-1:0] lat_row_r, lat_row_nxt_s;
    logic [IDX_W-1:0] lat_col_r, lat_col_nxt_s;
    logic             entry_r, entry_nxt_s;

    logic [ROWS-1:0]  row_s;
    logic [IDX_W-1:0] col_idx_s;
    logic             col_onehot_s;
    logic [IDX_W-1:0] row_idx_s;
    logic             sample_s;
    logic             hit_s;
    logic             multi_s;
    logic             good_hit_s;
    logic             col_match_s;
    logic             cand_match_s;
    logic             row_present_s;

    logic [KEY_W-1:0] key_code_r, key_code_nxt_s;
    logic             key_valid_r, key_valid_nxt_s;
    logic             key_held_r, key_held_nxt_s;
    logic             key_error_r, key_error_nxt_s;

    onehot_enc u_col_enc (
        .vec       (col),
        .idx       (col_idx_s),
        .is_onehot (col_onehot_s)
    );

    assign row_s = row;

    // Lowest set row bit wins
    always_comb begin
        if (row_s[0]) begin
            row_idx_s = 2'd0;
        end else if (row_s[1]) begin
            row_idx_s = 2'd1;
        end else if (row_s[2]) begin
            row_idx_s = 2'd2;
        end else if (row_s[3]) begin
            row_idx_s = 2'd3;
        end else begin
            row_idx_s = 2'd0;
        end
    end

`ifdef KEYPAD_MULTIKEY_ERR_EN
    assign multi_s = (row_s & (row_s - 4'd1)) != 4'b0000;
`else
    assign multi_s = 1'b0;
`endif

    assign sample_s      = enable & col_onehot_s;
    assign hit_s         = |row_s;
    assign good_hit_s    = hit_s & ~multi_s;
    assign col_match_s   = (col_idx_s == lat_col_r);
    assign cand_match_s  = good_hit_s & (row_idx_s == lat_row_r);
    assign row_present_s = row_s[lat_row_r] & ~multi_s;
    assign cnt_inc_s     = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZRO;
            lat_row_r <= 2'd0;
            lat_col_r <= 2'd0;
            entry_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            lat_row_r <= lat_row_nxt_s;
            lat_col_r <= lat_col_nxt_s;
            entry_r   <= entry_nxt_s;
        end
    end

    // Next-state logic; with enable low everything holds
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        lat_row_nxt_s = lat_row_r;
        lat_col_nxt_s = lat_col_r;
        entry_nxt_s   = entry_r;
        if (enable) begin
            case (state_r)
                IDLE: begin
                    if (sample_s && good_hit_s) begin
                        lat_row_nxt_s = row_idx_s;
                        lat_col_nxt_s = col_idx_s;
                        cnt_nxt_s     = CNT_ONE;
                        if (CNT_ONE == CNT_MAX) begin
                            state_nxt_s = PRESSED;
                            entry_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = CANDIDATE;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                CANDIDATE: begin
                    if (sample_s && col_match_s) begin
                        if (cand_match_s) begin
                            cnt_nxt_s = cnt_inc_s;
                            if (cnt_inc_s == CNT_MAX) begin
                                state_nxt_s = PRESSED;
                                entry_nxt_s = 1'b1;
                            end else begin
                                state_nxt_s = CANDIDATE;
                            end
                        end else begin
                            state_nxt_s = IDLE;
                            cnt_nxt_s   = CNT_ZRO;
                        end
                    end else begin
                        state_nxt_s = CANDIDATE;
                    end
                end
                PRESSED: begin
                    // The entry cycle only publishes the key and re-arms the release counter
                    if (entry_r) begin
                        cnt_nxt_s   = CNT_ZRO;
                        entry_nxt_s = 1'b0;
                    end else if (sample_s && col_match_s) begin
                        if (row_present_s) begin
                            cnt_nxt_s = CNT_ZRO;
                        end else if (cnt_inc_s == CNT_MAX) begin
                            state_nxt_s = IDLE;
                            cnt_nxt_s   = CNT_ZRO;
                        end else begin
                            cnt_nxt_s = cnt_inc_s;
                        end
                    end else begin
                        state_nxt_s = PRESSED;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZRO;
                    entry_nxt_s = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output next values: pulse on PRESSED entry, drop held on accepted release
    always_comb begin
        key_valid_nxt_s = 1'b0;
        key_code_nxt_s  = key_code_r;
        key_held_nxt_s  = key_held_r;
        key_error_nxt_s = 1'b0;
        if (enable) begin
            if (state_r == PRESSED && entry_r) begin
                key_valid_nxt_s = 1'b1;
                key_code_nxt_s  = pack_key(lat_row_r, lat_col_r);
                key_held_nxt_s  = 1'b1;
            end else if (state_r == PRESSED && state_nxt_s == IDLE) begin
                key_held_nxt_s = 1'b0;
            end else begin
                key_held_nxt_s = key_held_r;
            end
            key_error_nxt_s = sample_s & multi_s;
        end else begin
            key_valid_nxt_s = 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            key_code_r  <= 4'b0000;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            key_error_r <= 1'b0;
        end else begin
            key_code_r  <= key_code_nxt_s;
            key_valid_r <= key_valid_nxt_s;
            key_held_r  <= key_held_nxt_s;
            key_error_r <= key_error_nxt_s;
        end
    end

    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;
    assign key_error = key_error_r;

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder (DEBOUNCE_SCANS=4) with a key-code scoreboard.
module tb_keypad_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       key_error;

    always #5 clk = ~clk;

    keypad_decoder #(.DEBOUNCE_SCANS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .key_error (key_error)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_count = 0;
    int valid_cyc = 0;
    int err_pulses = 0;
    int hit_cyc = 0;
    int abs_cyc = 0;
    bit track_hit = 1'b0;
    bit track_abs = 1'b0;
    logic [3:0] km [4];
    logic [3:0] exp_q [$];
    logic [3:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every key_valid pulse must match the oldest expected code
    always begin
        @(posedge clk);
        #1;
        if (reset === 1'b1 && key_valid === 1'b1) begin
            valid_count++;
            valid_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: key_code=%b with no expected key", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_code !== mon_exp) begin
                    errors++;
                    $display("FAIL key_code: got %b expected %b", key_code, mon_exp);
                end
            end
        end
        if (key_error === 1'b1) err_pulses++;
    end

    function automatic int col_index(input logic [3:0] c);
        case (c)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        if (enable) col = {col[2:0], col[3]};
        row = km[col_index(col)];
        if (enable && track_hit && row != 4'b0000) begin
            hit_cyc = cyc + 1;
            track_hit = 1'b0;
        end
        if (enable && track_abs && col == 4'b0010 && row[2] == 1'b0) begin
            abs_cyc = cyc + 1;
            track_abs = 1'b0;
        end
    endtask

    task automatic wait_valid(input int start, output bit got);
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (valid_count > start) begin
                got = 1'b1;
                break;
            end
            step();
        end
        if (valid_count > start) got = 1'b1;
    endtask

    task automatic wait_release(output bit got, output int fall);
        got = 1'b0;
        fall = 0;
        for (int i = 0; i < 60; i++) begin
            if (key_held === 1'b0) begin
                got = 1'b1;
                fall = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic clear_keys();
        for (int c = 0; c < 4; c++) km[c] = 4'b0000;
    endtask

    task automatic test_reset();
        int start;
        for (int c = 0; c < 4; c++) km[c] = 4'b0010;
        reset = 1'b0;
        step();
        step();
        checks++;
        if (key_code !== 4'b0000 || key_valid !== 1'b0 || key_held !== 1'b0 || key_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: code=%b valid=%b held=%b err=%b expected all 0",
                     key_code, key_valid, key_held, key_error);
        end
        clear_keys();
        reset = 1'b1;
        start = valid_count;
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (valid_count != start || key_held !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_key: pulses=%0d held=%b expected 0 pulses held 0",
                     valid_count - start, key_held);
        end
    endtask

    task automatic test_press();
        bit got;
        int start = valid_count;
        track_hit = 1'b1;
        km[1] = 4'b0100;
        exp_q.push_back(4'b1001);
        wait_valid(start, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL press_timeout: no key_valid, expected one");
        end else if (valid_cyc - hit_cyc != 13) begin
            errors++;
            $display("FAIL press_latency: got %0d cycles expected 13", valid_cyc - hit_cyc);
        end
        checks++;
        if (key_held !== 1'b1 || key_code !== 4'b1001 || key_valid !== 1'b1) begin
            errors++;
            $display("FAIL press_outputs: held=%b code=%b valid=%b expected 1/1001/1",
                     key_held, key_code, key_valid);
        end
        step();
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL press_pulse_width: key_valid=%b expected 0", key_valid);
        end
    endtask

    task automatic test_release();
        bit got;
        int fall;
        int start;
        km[1] = 4'b0000;
        track_abs = 1'b1;
        wait_release(got, fall);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL release_timeout: key_held stuck at %b expected 0", key_held);
        end else if (fall - abs_cyc < 12 || fall - abs_cyc > 16) begin
            errors++;
            $display("FAIL release_latency: got %0d cycles expected 12..16", fall - abs_cyc);
        end
        checks++;
        if (key_code !== 4'b1001) begin
            errors++;
            $display("FAIL release_code_hold: got %b expected 1001", key_code);
        end
        start = valid_count;
        km[1] = 4'b0100;
        exp_q.push_back(4'b1001);
        wait_valid(start, got);
        checks++;
        if (!got || key_held !== 1'b1) begin
            errors++;
            $display("FAIL repress: got_valid=%b held=%b expected 1/1", got, key_held);
        end
    endtask

    task automatic test_second_key();
        bit got;
        int fall;
        int start = valid_count;
        km[3] = 4'b0001;
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (valid_count != start || key_code !== 4'b1001 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL second_key_ignored: pulses=%0d code=%b held=%b expected 0/1001/1",
                     valid_count - start, key_code, key_held);
        end
        clear_keys();
        wait_release(got, fall);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL second_key_release: key_held=%b expected 0", key_held);
        end
    endtask

    task automatic test_bounce();
        bit got;
        int fall;
        int start = valid_count;
        km[1] = 4'b0100;
        for (int i = 0; i < 8; i++) step();
        km[1] = 4'b0000;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (valid_count != start) begin
            errors++;
            $display("FAIL bounce_early: pulses=%0d expected 0", valid_count - start);
        end
        track_hit = 1'b1;
        km[1] = 4'b0100;
        exp_q.push_back(4'b1001);
        wait_valid(start, got);
        checks++;
        if (!got || valid_cyc - hit_cyc != 13) begin
            errors++;
            $display("FAIL bounce_latency: got_valid=%b latency=%0d expected 13", got, valid_cyc - hit_cyc);
        end
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (valid_count != start + 1) begin
            errors++;
            $display("FAIL bounce_pulses: got %0d expected 1", valid_count - start);
        end
        clear_keys();
        wait_release(got, fall);
    endtask

    task automatic test_multikey();
        bit got;
        int fall;
        int start = valid_count;
        int e0 = err_pulses;
        km[2] = 4'b0101;
`ifdef KEYPAD_MULTIKEY_ERR_EN
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (err_pulses - e0 != 5 || valid_count != start) begin
            errors++;
            $display("FAIL multikey_err: error_pulses=%0d pulses=%0d expected 5/0",
                     err_pulses - e0, valid_count - start);
        end
`else
        exp_q.push_back(4'b0010);
        wait_valid(start, got);
        checks++;
        if (!got || err_pulses != e0) begin
            errors++;
            $display("FAIL multikey_lowest: got_valid=%b error_pulses=%0d expected 1/0",
                     got, err_pulses - e0);
        end
`endif
        clear_keys();
        wait_release(got, fall);
    endtask

    task automatic test_enable_freeze();
        bit got;
        int start = valid_count;
        track_hit = 1'b1;
        km[1] = 4'b0100;
        exp_q.push_back(4'b1001);
        for (int i = 0; i < 8 && track_hit; i++) step();
        for (int i = 0; i < 5; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (valid_count != start || key_held !== 1'b0) begin
            errors++;
            $display("FAIL freeze_hold: pulses=%0d held=%b expected 0/0", valid_count - start, key_held);
        end
        enable = 1'b1;
        wait_valid(start, got);
        checks++;
        if (!got || valid_cyc - hit_cyc != 23) begin
            errors++;
            $display("FAIL freeze_latency: got_valid=%b latency=%0d expected 23", got, valid_cyc - hit_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int start = valid_count;
        clear_keys();
        reset = 1'b0;
        step();
        checks++;
        if (key_held !== 1'b0 || key_code !== 4'b0000 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: held=%b code=%b valid=%b expected 0/0000/0",
                     key_held, key_code, key_valid);
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (valid_count != start) begin
            errors++;
            $display("FAIL reset_mid_quiet: pulses=%0d expected 0", valid_count - start);
        end
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        col    = 4'b0001;
        row    = 4'b0000;
        clear_keys();
        test_reset();
        test_press();
        test_release();
        test_second_key();
        test_bounce();
        test_multikey();
        test_enable_freeze();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected keys never seen, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
